// File: rtl/gpio_bank_ctrl_if.sv
// Pin bank bus: pad levels, per-pin configuration and status.
// All signals are level-based and sampled on io_sys_clock; there is no
// valid/ready handshake. irq_clr is the only strobe: each 1 bit is
// honoured on the single clock edge where it is seen high.
interface gpio_bank_ctrl_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] io_pins_read;
  logic [WIDTH-1:0] io_pins_write;
  logic [WIDTH-1:0] io_pins_writeEnable;
  logic [WIDTH-1:0] cfg_out;
  logic [WIDTH-1:0] cfg_oe;
  logic [WIDTH-1:0] cfg_od;
  logic [WIDTH-1:0] cfg_rise_en;
  logic [WIDTH-1:0] cfg_fall_en;
  logic [WIDTH-1:0] irq_clr;
  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] pending;
  logic             irq;

  modport master (
    output io_pins_read, cfg_out, cfg_oe, cfg_od, cfg_rise_en, cfg_fall_en, irq_clr,
    input  io_pins_write, io_pins_writeEnable, value, pending, irq
  );

  modport slave (
    input  io_pins_read, cfg_out, cfg_oe, cfg_od, cfg_rise_en, cfg_fall_en, irq_clr,
    output io_pins_write, io_pins_writeEnable, value, pending, irq
  );
endinterface

// File: rtl/gpio_bank_ctrl.sv
// GPIO bank: registered pad drivers (push-pull / open-drain), per-pin
// input synchroniser and debouncer, and sticky edge-event flags with irq.
module gpio_bank_ctrl #(
  parameter int WIDTH        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CNT = 4
) (
  input logic             io_sys_clock,
  input logic             io_sys_reset,
  gpio_bank_ctrl_if.slave bus
);
  // A counter at CNT_TOP means this edge is the DEBOUNCE_CNT-th differing cycle.
  localparam logic [15:0] CNT_TOP = 16'(DEBOUNCE_CNT - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0][15:0]            cnt_q;
  logic [WIDTH-1:0][15:0]            cnt_nxt;
  logic [WIDTH-1:0]                  value_q;
  logic [WIDTH-1:0]                  value_nxt;
  logic [WIDTH-1:0]                  pend_q;
  logic [WIDTH-1:0]                  pend_nxt;
  logic [WIDTH-1:0]                  write_q;
  logic [WIDTH-1:0]                  we_q;
  logic [WIDTH-1:0]                  sync_lvl;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Pad drivers: open-drain pins never drive high, they release to high-Z instead.
  always_ff @(posedge io_sys_clock or posedge io_sys_reset) begin
    if (io_sys_reset) begin
      write_q <= '0;
      we_q    <= '0;
    end else begin
      write_q <= bus.cfg_out & ~bus.cfg_od;
      we_q    <= bus.cfg_oe & ~(bus.cfg_od & bus.cfg_out);
    end
  end

  // Synchroniser chain; readback of driven pins goes through here as well.
  always_ff @(posedge io_sys_clock or posedge io_sys_reset) begin
    if (io_sys_reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= bus.io_pins_read;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Debounce and event capture; a set on the same edge as a clear wins.
  always_comb begin
    cnt_nxt   = cnt_q;
    value_nxt = value_q;
    pend_nxt  = pend_q & ~bus.irq_clr;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_lvl[i] == value_q[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt_q[i] == CNT_TOP) begin
        cnt_nxt[i]   = '0;
        value_nxt[i] = sync_lvl[i];
        if (sync_lvl[i] ? bus.cfg_rise_en[i] : bus.cfg_fall_en[i]) begin
          pend_nxt[i] = 1'b1;
        end
      end else begin
        cnt_nxt[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  // State registers for the debounce counters, accepted levels and pending flags.
  always_ff @(posedge io_sys_clock or posedge io_sys_reset) begin
    if (io_sys_reset) begin
      cnt_q   <= '0;
      value_q <= '0;
      pend_q  <= '0;
    end else begin
      cnt_q   <= cnt_nxt;
      value_q <= value_nxt;
      pend_q  <= pend_nxt;
    end
  end

  assign bus.io_pins_write       = write_q;
  assign bus.io_pins_writeEnable = we_q;
  assign bus.value               = value_q;
  assign bus.pending             = pend_q;
  assign bus.irq                 = |pend_q;
endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Bench for gpio_bank_ctrl: output-path vector table, hand-written
// debounce/interrupt/reset sequences, and a random run against a
// window-based reference model of the default 4-pin bank.
module tb_gpio_bank_ctrl;
  localparam int W  = 4;
  localparam int S  = 2;
  localparam int D  = 4;
  localparam int HL = S + D;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   chk_en;

  gpio_bank_ctrl_if #(.WIDTH(W))  bus_a ();
  gpio_bank_ctrl_if #(.WIDTH(32)) bus_b ();

  gpio_bank_ctrl #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CNT(D)) dut_a (
    .io_sys_clock(clk),
    .io_sys_reset(rst),
    .bus(bus_a)
  );

  gpio_bank_ctrl #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CNT(1)) dut_b (
    .io_sys_clock(clk),
    .io_sys_reset(rst),
    .bus(bus_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a pin accepts a new level when the last D synchronised
  // samples (pad samples taken S..S+D-1 edges ago) all oppose its value.
  bit         ph [W][HL];
  logic [W-1:0] m_value, m_pend, m_w, m_we;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < W; i++)
        for (int k = 0; k < HL; k++) ph[i][k] = 1'b0;
      m_value = '0;
      m_pend  = '0;
      m_w     = '0;
      m_we    = '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        bit all_opp;
        bit set_ev;
        for (int k = HL - 1; k > 0; k--) ph[i][k] = ph[i][k-1];
        ph[i][0] = bus_a.io_pins_read[i];
        all_opp = 1'b1;
        for (int k = S; k < HL; k++)
          if (ph[i][k] == m_value[i]) all_opp = 1'b0;
        set_ev = 1'b0;
        if (all_opp) begin
          m_value[i] = ~m_value[i];
          set_ev = m_value[i] ? bus_a.cfg_rise_en[i] : bus_a.cfg_fall_en[i];
        end
        if (set_ev) m_pend[i] = 1'b1;
        else if (bus_a.irq_clr[i]) m_pend[i] = 1'b0;
        m_w[i]  = bus_a.cfg_od[i] ? 1'b0 : bus_a.cfg_out[i];
        m_we[i] = bus_a.cfg_od[i] ? (bus_a.cfg_oe[i] & ~bus_a.cfg_out[i]) : bus_a.cfg_oe[i];
      end
    end
  end

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus_a.io_pins_read = '0; bus_a.cfg_out = '0; bus_a.cfg_oe = '0; bus_a.cfg_od = '0;
    bus_a.cfg_rise_en = '0; bus_a.cfg_fall_en = '0; bus_a.irq_clr = '0;
    bus_b.io_pins_read = '0; bus_b.cfg_out = '0; bus_b.cfg_oe = '0; bus_b.cfg_od = '0;
    bus_b.cfg_rise_en = '0; bus_b.cfg_fall_en = '0; bus_b.irq_clr = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    #1;
    chk("rst_value",   32'(bus_a.value), 32'h0);
    chk("rst_pending", 32'(bus_a.pending), 32'h0);
    chk("rst_irq",     32'(bus_a.irq), 32'h0);
    chk("rst_write",   32'(bus_a.io_pins_write), 32'h0);
    chk("rst_we",      32'(bus_a.io_pins_writeEnable), 32'h0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] out;
    logic [W-1:0] oe;
    logic [W-1:0] od;
    logic [W-1:0] exp_w;
    logic [W-1:0] exp_we;
  } vec_t;

  vec_t vecs [7];
  int   hold [W];

  initial begin
    logic [W-1:0] prev_w, prev_we;
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    rst = 1'b1;
    clear_inputs();

    vecs[0] = '{4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b1111};
    vecs[1] = '{4'b1010, 4'b0110, 4'b0000, 4'b1010, 4'b0110};
    vecs[2] = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    vecs[3] = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b1000};
    vecs[4] = '{4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
    vecs[5] = '{4'b0101, 4'b1111, 4'b1111, 4'b0000, 4'b1010};
    vecs[6] = '{4'b0110, 4'b1100, 4'b0101, 4'b0010, 4'b1000};

    tick();
    do_reset();

    // output path table: old value until the edge, new value after it
    prev_w  = '0;
    prev_we = '0;
    for (int v = 0; v < 7; v++) begin
      bus_a.cfg_out = vecs[v].out;
      bus_a.cfg_oe  = vecs[v].oe;
      bus_a.cfg_od  = vecs[v].od;
      #1;
      chk("vec_w_hold",  32'(bus_a.io_pins_write), 32'(prev_w));
      chk("vec_we_hold", 32'(bus_a.io_pins_writeEnable), 32'(prev_we));
      tick();
      chk("vec_w",  32'(bus_a.io_pins_write), 32'(vecs[v].exp_w));
      chk("vec_we", 32'(bus_a.io_pins_writeEnable), 32'(vecs[v].exp_we));
      prev_w  = vecs[v].exp_w;
      prev_we = vecs[v].exp_we;
    end

    // rising edge on pin0: value and pending exactly S+D cycles later
    do_reset();
    bus_a.io_pins_read[0] = 1'b1;
    bus_a.cfg_rise_en[0]  = 1'b1;
    repeat (HL - 1) tick();
    chk("rise_early_value", 32'(bus_a.value), 32'h0);
    chk("rise_early_pend",  32'(bus_a.pending), 32'h0);
    tick();
    chk("rise_value", 32'(bus_a.value), 32'h1);
    chk("rise_pend",  32'(bus_a.pending), 32'h1);
    chk("rise_irq",   32'(bus_a.irq), 32'h1);

    // 3-cycle glitch on pin1 is rejected
    do_reset();
    bus_a.cfg_rise_en = 4'b0010;
    bus_a.cfg_fall_en = 4'b0010;
    bus_a.io_pins_read[1] = 1'b1;
    repeat (3) tick();
    bus_a.io_pins_read[1] = 1'b0;
    repeat (5) tick();
    chk("glitch_value_mid", 32'(bus_a.value), 32'h0);
    repeat (5) tick();
    chk("glitch_value", 32'(bus_a.value), 32'h0);
    chk("glitch_pend",  32'(bus_a.pending), 32'h0);

    // set wins over simultaneous clear on pin2, lone clear then works
    do_reset();
    bus_a.cfg_rise_en[2]  = 1'b1;
    bus_a.cfg_fall_en[2]  = 1'b1;
    bus_a.io_pins_read[2] = 1'b1;
    repeat (HL) tick();
    chk("p2_set_pend", 32'(bus_a.pending), 32'h4);
    bus_a.io_pins_read[2] = 1'b0;
    repeat (HL - 1) tick();
    chk("p2_fall_early", 32'(bus_a.value), 32'h4);
    bus_a.irq_clr[2] = 1'b1;
    tick();
    bus_a.irq_clr[2] = 1'b0;
    chk("p2_fall_value", 32'(bus_a.value), 32'h0);
    chk("p2_setwins",    32'(bus_a.pending), 32'h4);
    bus_a.cfg_fall_en[2] = 1'b0;
    tick();
    chk("p2_sticky", 32'(bus_a.pending), 32'h4);
    bus_a.irq_clr[2] = 1'b1;
    tick();
    bus_a.irq_clr[2] = 1'b0;
    chk("p2_clr_pend", 32'(bus_a.pending), 32'h0);
    chk("p2_clr_irq",  32'(bus_a.irq), 32'h0);

    // reset mid-debounce discards the count; re-acquire after release
    do_reset();
    bus_a.cfg_oe  = 4'b1111;
    bus_a.cfg_out = 4'b1111;
    bus_a.cfg_rise_en = 4'b0001;
    bus_a.io_pins_read = 4'b0011;
    repeat (S + 2) tick();
    chk("mid_we_pre", 32'(bus_a.io_pins_writeEnable), 32'hF);
    rst = 1'b1;
    #1;
    chk("mid_rst_we",    32'(bus_a.io_pins_writeEnable), 32'h0);
    chk("mid_rst_write", 32'(bus_a.io_pins_write), 32'h0);
    chk("mid_rst_value", 32'(bus_a.value), 32'h0);
    chk("mid_rst_irq",   32'(bus_a.irq), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    repeat (HL - 1) tick();
    chk("mid_rel_early", 32'(bus_a.value), 32'h0);
    tick();
    chk("mid_rel_value", 32'(bus_a.value), 32'h3);
    chk("mid_rel_pend",  32'(bus_a.pending), 32'h1);

    // wide bank, DEBOUNCE_CNT=1: all pins in the same cycle
    do_reset();
    bus_b.cfg_rise_en = '1;
    bus_b.cfg_fall_en = '1;
    bus_b.io_pins_read = '1;
    repeat (2) tick();
    chk("wide_early", bus_b.pending, 32'h0);
    tick();
    chk("wide_rise_pend",  bus_b.pending, 32'hFFFFFFFF);
    chk("wide_rise_value", bus_b.value, 32'hFFFFFFFF);
    bus_b.irq_clr = '1;
    tick();
    bus_b.irq_clr = '0;
    chk("wide_clr", bus_b.pending, 32'h0);
    bus_b.io_pins_read = '0;
    repeat (3) tick();
    chk("wide_fall_pend",  bus_b.pending, 32'hFFFFFFFF);
    chk("wide_fall_value", bus_b.value, 32'h0);

    // random run against the reference model
    do_reset();
    for (int i = 0; i < W; i++) hold[i] = $urandom_range(1, 7);
    for (int c = 0; c < 600; c++) begin
      chk("rnd_value",   32'(bus_a.value), 32'(m_value));
      chk("rnd_pending", 32'(bus_a.pending), 32'(m_pend));
      chk("rnd_irq",     32'(bus_a.irq), 32'(|m_pend));
      chk("rnd_write",   32'(bus_a.io_pins_write), 32'(m_w));
      chk("rnd_we",      32'(bus_a.io_pins_writeEnable), 32'(m_we));
      for (int i = 0; i < W; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin
          bus_a.io_pins_read[i] = ~bus_a.io_pins_read[i];
          hold[i] = $urandom_range(1, 8);
        end
      end
      bus_a.cfg_out     = W'($urandom);
      bus_a.cfg_oe      = W'($urandom);
      bus_a.cfg_od      = W'($urandom);
      if ((c % 40) == 0) begin
        bus_a.cfg_rise_en = W'($urandom);
        bus_a.cfg_fall_en = W'($urandom);
      end
      bus_a.irq_clr = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
